// File: rtl/hazard_ctrl.sv
// hazard_ctrl: interlock and forwarding scheduler beside the ID stage.
// Tracks the EXE/MEM destination registers in a small scoreboard and drives
// operand forwarding selects, load-use stalls, redirect flushes and the
// global freeze for external memory wait.
// Optional: define HAZ_STATS_EN to add saturating stall/flush/freeze counters.
module hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int STAT_W = 16
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic [RA_W-1:0] id_rn,
    input  logic [1:0]      pcsource,
    input  logic            ext_stall,
`ifdef HAZ_STATS_EN
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt,
    output logic [STAT_W-1:0] freeze_cnt,
`endif
    output logic            wpcir,
    output logic            bubble,
    output logic            flush_ifid,
    output logic            pipe_en,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // scoreboard: destination info of the instructions now in EXE and MEM
    logic            r_ex_wreg, r_ex_m2reg;
    logic [RA_W-1:0] r_ex_rn;
    logic            r_mm_wreg, r_mm_m2reg;
    logic [RA_W-1:0] r_mm_rn;

    logic w_lu;
    logic w_redirect;
    logic w_ex_valid, w_mm_valid;

    // register 0 is hard-wired, so a write to it never creates a dependency
    assign w_ex_valid = r_ex_wreg && (r_ex_rn != '0);
    assign w_mm_valid = r_mm_wreg && (r_mm_rn != '0);
    assign w_redirect = |pcsource;

    // load in EXE whose result the ID instruction needs: data not yet available
    assign w_lu = w_ex_valid && r_ex_m2reg &&
                  ((id_use_rs && (r_ex_rn == id_rs)) ||
                   (id_use_rt && (r_ex_rn == id_rt)));

    // operand forwarding; EXE beats MEM because it holds the youngest value
    always_comb begin
        fwda = 2'b00;
        fwdb = 2'b00;
        if (clrn) begin
            if (id_use_rs && w_ex_valid && !r_ex_m2reg && (r_ex_rn == id_rs))
                fwda = 2'b01;
            else if (id_use_rs && w_mm_valid && (r_mm_rn == id_rs))
                fwda = r_mm_m2reg ? 2'b11 : 2'b10;

            if (id_use_rt && w_ex_valid && !r_ex_m2reg && (r_ex_rn == id_rt))
                fwdb = 2'b01;
            else if (id_use_rt && w_mm_valid && (r_mm_rn == id_rt))
                fwdb = r_mm_m2reg ? 2'b11 : 2'b10;
        end
    end

    // pipeline control; priority is freeze, then load-use, then redirect flush
    always_comb begin
        wpcir      = 1'b1;
        pipe_en    = 1'b1;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        if (clrn) begin
            if (ext_stall) begin
                wpcir   = 1'b0;
                pipe_en = 1'b0;
            end else if (w_lu) begin
                // branch operands are not ready; the redirect re-evaluates next cycle
                wpcir  = 1'b0;
                bubble = 1'b1;
            end else if (w_redirect) begin
                flush_ifid = 1'b1;
            end
        end
    end

    // next-state: stall is a single cycle, freeze holds while memory waits
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (ext_stall)  w_state_nxt = FREEZE;
                else if (w_lu)  w_state_nxt = STALL;
            end
            STALL:  w_state_nxt = RUN;
            FREEZE: begin
                if (!ext_stall) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // scoreboard shift; a bubble enters EXE as a no-write instruction
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ex_wreg  <= 1'b0;
            r_ex_m2reg <= 1'b0;
            r_ex_rn    <= '0;
            r_mm_wreg  <= 1'b0;
            r_mm_m2reg <= 1'b0;
            r_mm_rn    <= '0;
        end else if (pipe_en) begin
            r_ex_wreg  <= bubble ? 1'b0 : id_wreg;
            r_ex_m2reg <= bubble ? 1'b0 : id_m2reg;
            r_ex_rn    <= bubble ? '0   : id_rn;
            r_mm_wreg  <= r_ex_wreg;
            r_mm_m2reg <= r_ex_m2reg;
            r_mm_rn    <= r_ex_rn;
        end
    end

`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;

    // saturating event counters
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (bubble && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_ifid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (ext_stall && (r_freeze_cnt != '1))
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives one ID-stage situation
// and checks {wpcir, bubble, flush_ifid, pipe_en, fwda, fwdb} against
// hand-computed values.
module tb_hazard_ctrl;

    localparam int RA_W   = 5;
    localparam int STAT_W = 16;

    logic            clk = 1'b0;
    logic            clrn;
    logic [RA_W-1:0] id_rs, id_rt, id_rn;
    logic            id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic [1:0]      pcsource;
    logic            ext_stall;
    logic            wpcir, bubble, flush_ifid, pipe_en;
    logic [1:0]      fwda, fwdb;
`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(.RA_W(RA_W), .STAT_W(STAT_W)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wreg    (id_wreg),
        .id_m2reg   (id_m2reg),
        .id_rn      (id_rn),
        .pcsource   (pcsource),
        .ext_stall  (ext_stall),
`ifdef HAZ_STATS_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .freeze_cnt (freeze_cnt),
`endif
        .wpcir      (wpcir),
        .bubble     (bubble),
        .flush_ifid (flush_ifid),
        .pipe_en    (pipe_en),
        .fwda       (fwda),
        .fwdb       (fwdb)
    );

    always #5 clk = ~clk;

    // set ID-stage inputs
    task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic wr, input logic m2, input logic [4:0] rn,
                       input logic [1:0] pcs, input logic ext);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr; id_m2reg = m2; id_rn = rn;
        pcsource = pcs; ext_stall = ext;
    endtask

    // advance one clock edge, then settle before driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // compare {wpcir,bubble,flush,pipe_en,fwda,fwdb}
    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        #1;
        obs = {wpcir, bubble, flush_ifid, pipe_en, fwda, fwdb};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed wpcir/bub/fl/pen/fa/fb=%b required %b", tag, obs, exp);
        end
    endtask

    localparam logic [7:0] DEF = 8'b1001_0000;   // run, no forwarding
    localparam logic [7:0] LU  = 8'b0101_0000;   // load-use stall
    localparam logic [7:0] FRZ = 8'b0000_0000;   // frozen

    initial begin
        // reset, with hostile inputs that must be masked
        clrn = 1'b0;
        drv(5'd3, 5'd3, 1, 1, 1, 1, 5'd3, 2'b01, 1);
        chk("reset_masked", DEF);
        drv(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 2'b00, 0);
        chk("reset_idle", DEF);
        step(); step();
        clrn = 1'b1;
        #1;

        // ALU r3 enters EXE
        drv(5'd0, 5'd0, 0, 0, 1, 0, 5'd3, 2'b00, 0);
        chk("alu_r3_issue", DEF);
        step();
        // use rs=3 -> EXE forward; rt=4 untouched
        drv(5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 2'b00, 0);
        chk("fwd_ex_rs", 8'b1001_0100);
        step();
        // r3 now in MEM; ID is a load to r5
        drv(5'd3, 5'd0, 1, 0, 1, 1, 5'd5, 2'b00, 0);
        chk("fwd_mem_alu", 8'b1001_1000);
        step();
        // use rt=5 against the load in EXE -> one stall cycle
        drv(5'd0, 5'd5, 0, 1, 0, 0, 5'd0, 2'b00, 0);
        chk("lu_stall", LU);
        step();
        chk("lu_after_fwd11", 8'b1001_0011);
        step();

        // load r5, then beq on r5 with redirect
        drv(5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 2'b00, 0);
        chk("load_r5_issue", DEF);
        step();
        drv(5'd5, 5'd0, 1, 1, 0, 0, 5'd0, 2'b01, 0);
        chk("lu_branch_noflush", LU);
        step();
        chk("branch_flush", 8'b1011_1100);
        step();

        // two writes of r7: EXE must win over MEM
        drv(5'd0, 5'd0, 0, 0, 1, 0, 5'd7, 2'b00, 0);
        chk("r7_first", DEF);
        step();
        chk("r7_second", DEF);
        step();
        drv(5'd7, 5'd7, 1, 1, 0, 0, 5'd0, 2'b00, 0);
        chk("youngest_wins", 8'b1001_0101);
        step();

        // destination r0 never matches
        drv(5'd0, 5'd0, 0, 0, 1, 1, 5'd0, 2'b00, 0);
        chk("load_r0_issue", DEF);
        step();
        drv(5'd0, 5'd0, 1, 0, 1, 0, 5'd0, 2'b00, 0);
        chk("r0_no_stall", DEF);
        step();
        drv(5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 2'b00, 0);
        chk("r0_no_fwd", DEF);
        step();

        // external freeze on top of a load-use
        drv(5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 2'b00, 0);
        chk("load_r5_again", DEF);
        step();
        drv(5'd0, 5'd5, 0, 1, 0, 0, 5'd0, 2'b00, 1);
        chk("freeze_1", FRZ);
        step();
        chk("freeze_2", FRZ);
        step();
        chk("freeze_3", FRZ);
        step();
        ext_stall = 1'b0;
        chk("post_freeze_lu", LU);
        step();
        chk("post_freeze_fwd11", 8'b1001_0011);
        step();

        // reset asserted in the middle of a stall
        drv(5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 2'b00, 0);
        chk("load_r5_pre_rst", DEF);
        step();
        drv(5'd0, 5'd5, 0, 1, 0, 0, 5'd0, 2'b00, 0);
        chk("stall_pre_rst", LU);
        clrn = 1'b0;
        chk("rst_mid_stall", DEF);
        pcsource  = 2'b01;
        ext_stall = 1'b1;
        chk("rst_mid_masked", DEF);
        step();
        pcsource  = 2'b00;
        ext_stall = 1'b0;
        clrn = 1'b1;
        chk("rst_release_clear", DEF);
        step();
        chk("rst_no_stall_survives", DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // hard time limit so the bench cannot hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock and forwarding scheduler for the 5-stage CPU. It sits beside the ID stage.
- Tracks the destination register, wreg and m2reg of the instructions in EXE and MEM in an internal scoreboard.
- Drives forwarding selects for ID operands a/b, load-use stalls (PC and IF/ID hold plus an EXE bubble), IF/ID flush on a taken branch or jump, and a global freeze for external wait.
- Regfile writes on ~clk, so WB-stage dependencies need no forwarding.

Parameters:
- RA_W, 5, register-number width
- STAT_W, 16, width of the optional statistics counters

Ports:
- clk  in  1  pipeline clock, rising edge
- clrn  in  1  asynchronous active-low reset
- id_rs  in  RA_W  ID source register rs (inst[9:5])
- id_rt  in  RA_W  ID source register rt (inst[4:0])
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes a register
- id_m2reg  in  1  ID instruction is a load
- id_rn  in  RA_W  ID destination register (after rd/rt mux)
- pcsource  in  2  ID next-PC select; nonzero means redirect (branch taken or jump)
- ext_stall  in  1  external memory wait; freezes the whole pipeline
- wpcir  out  1  PC and IF/ID write enable
- bubble  out  1  zero all ID→EXE control (wreg, wmem, m2reg)
- flush_ifid  out  1  squash the IF/ID instruction at the next edge
- pipe_en  out  1  write enable for the ID/EXE, EXE/MEM and MEM/WB registers
- fwda  out  2  operand-a source: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- fwdb  out  2  operand-b source, same encoding as fwda

Behaviour:
- Scoreboard registers: ex_wreg, ex_m2reg, ex_rn, mm_wreg, mm_m2reg, mm_rn. All are reset to 0 asynchronously when clrn=0.
- Scoreboard update on each rising edge with pipe_en=1:
  - ex_* <= bubble ? 0 : id_*
  - mm_* <= ex_*
- When pipe_en=0, the scoreboard holds.
- Register 0 never matches: any compare against rn=0 is false.
- Forwarding for fwda (fwdb identical using id_rt / id_use_rt); combinational, first match wins:
  1. use && ex_wreg && !ex_m2reg && ex_rn==rs → 01
  2. use && mm_wreg && mm_rn==rs → mm_m2reg ? 11 : 10
  3. otherwise → 00
  - The EXE match has priority over MEM because it holds the youngest value.
- Load-use: lu = ex_wreg && ex_m2reg && ex_rn!=0 && ((id_use_rs && ex_rn==id_rs) || (id_use_rt && ex_rn==id_rt)).
- FSM, states RUN, STALL, FREEZE:
  - RUN:
    - ext_stall=1 → FREEZE
    - otherwise, lu=1 → STALL
  - STALL: lasts exactly one cycle, then → RUN. After the stall the load is in MEM and is covered by forwarding 11.
  - FREEZE: stays while ext_stall=1. When ext_stall=0 → RUN, and lu is re-evaluated in that same cycle.
- Outputs are combinational from state and inputs:
  - ext_stall=1 (in any state): pipe_en=0, wpcir=0, bubble=0, flush_ifid=0
  - lu=1: pipe_en=1, wpcir=0, bubble=1, flush_ifid=0. A redirect is ignored because the branch operands are not ready; the branch re-evaluates next cycle.
  - pcsource!=0 and no stall: flush_ifid=1, wpcir=1, bubble=0
  - otherwise: wpcir=1, pipe_en=1, bubble=0, flush_ifid=0
- Priority: ext_stall > load-use > flush.
- Reset values: state=RUN. While clrn=0: wpcir=1, pipe_en=1, bubble=0, flush_ifid=0, fwda=fwdb=00.
- Reset asserted mid-stall: the scoreboard clears immediately and no stall survives reset.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: adds outputs stall_cnt, flush_cnt, freeze_cnt (STAT_W each).
  - Each increments on an edge where the lu stall, flush_ifid or ext_stall respectively is active.
  - Each saturates at all-ones and is reset to 0 by clrn.
- Undefined: no counters and no counter ports.

Test Plan:
- ALU r3 in EXE (ex_rn=3, wreg=1, m2reg=0); ID uses rs=3 → fwda=01, fwdb=00, wpcir=1, no bubble.
- Load to r5 in EXE; ID uses rt=5 → exactly one cycle with wpcir=0, bubble=1. Next cycle fwdb=11, wpcir=1.
- Load to r5 in EXE; ID beq on r5 with pcsource=01 → flush_ifid=0 during the stall. The following cycle has flush_ifid=1.
- ALU r7 in EXE and an older write to r7 in MEM; ID uses rs=7 → fwda=01 (youngest wins).
- Destination r0 in EXE/MEM with wreg=1; ID uses rs=0 → fwda=00, no stall.
- ext_stall high for 3 cycles during a load-use → pipe_en=0 and the scoreboard holds. After release, one stall cycle follows. Pulse clrn low mid-sequence → all outputs return to reset values immediately.
